// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci request/response sequencer.
// The prev seed F(-1)=1 makes F(0)+F(-1) produce F(1) on the first advance.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } fib_state_t;

  localparam int unsigned FIB_NEG1 = 1;

endpackage

// File: rtl/fibonacci.sv
// Fibonacci term generator: f_num walks F(0), F(1), ... one term per enabled edge.
// Terms wrap modulo 2^N; rst returns to F(0) on the next edge.
module fibonacci #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [N-1:0] f_num
);

  logic [N-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_num  <= '0;
      r_prev <= N'(1);
    end else if (en) begin
      f_num  <= f_num + r_prev;
      r_prev <= f_num;
    end
  end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Valid/ready sequencer that steers one Fibonacci generator to term k and
// returns F(k) mod 2^N, reusing the generator's position when k is not behind it.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [IW-1:0] req_idx,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_ovf,
  output logic          busy,
  output logic          gen_clr,
  output logic          gen_en,
  input  logic [N-1:0]  gen_num
);

  fib_state_t    r_state;
  logic [IW-1:0] r_tgt;
  logic [IW-1:0] r_curIdx;
  logic [N-1:0]  r_prev;
  logic          r_genVld;
  logic          r_ovfSeen;

  logic [N:0]    w_nextSum;
  logic          w_atTarget;

  // Carry out of the next generator term marks the first wrapped value.
  assign w_nextSum  = {1'b0, gen_num} + {1'b0, r_prev};
  assign w_atTarget = (r_curIdx == r_tgt);

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign gen_clr   = (r_state == CLR);
  assign gen_en    = (r_state == RUN) && !w_atTarget;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tgt     <= '0;
      r_curIdx  <= '0;
      r_prev    <= '0;
      r_genVld  <= 1'b0;
      r_ovfSeen <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_tgt <= req_idx;
            if (r_genVld && (req_idx >= r_curIdx)) begin
              r_state <= RUN;
            end else begin
              r_state <= CLR;
            end
          end
        end
        CLR: begin
          r_curIdx  <= '0;
          r_prev    <= N'(FIB_NEG1);
          r_ovfSeen <= 1'b0;
          r_genVld  <= 1'b1;
          r_state   <= RUN;
        end
        RUN: begin
          if (w_atTarget) begin
            rsp_data  <= gen_num;
            rsp_ovf   <= r_ovfSeen;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_curIdx  <= r_curIdx + 1'b1;
            r_prev    <= gen_num;
            r_ovfSeen <= r_ovfSeen | w_nextSum[N];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed scoreboard bench for fib_seq_ctrl driving a real fibonacci generator.
// Expected terms come from an exact 64-bit Fibonacci reference, not the RTL recurrence.
module tb_fib_seq_ctrl;

  localparam int N  = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_idx;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          rsp_ovf;
  logic          busy;
  logic          gen_clr;
  logic          gen_en;
  logic [N-1:0]  gen_num;
  logic          w_genRst;

  typedef struct {
    int idx;
    longint data;
    longint ovf;
    int lat;
    int clrPulses;
    int clrStart;
  } exp_t;

  exp_t sbQ[$];

  int checks    = 0;
  int failures  = 0;
  int clrCount  = 0;
  bit modelVld  = 1'b0;
  int modelIdx  = 0;

  always #5 clk = ~clk;

  assign w_genRst = rst | gen_clr;

  fib_seq_ctrl #(.N(N), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .gen_clr   (gen_clr),
    .gen_en    (gen_en),
    .gen_num   (gen_num)
  );

  fibonacci #(.N(N)) gen (
    .clk   (clk),
    .rst   (w_genRst),
    .en    (gen_en),
    .f_num (gen_num)
  );

  // Clear pulses are counted at the edge where the generator samples them.
  always @(posedge clk) begin
    if (gen_clr) clrCount++;
  end

  function automatic longint fibTrue(int k);
    longint a = 0;
    longint b = 1;
    longint t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one request and records what the DUT must eventually return.
  task automatic applyStimulus(int k);
    exp_t e;
    bit   clearPath;
    longint f;
    clearPath   = !modelVld || (k < modelIdx);
    f           = fibTrue(k);
    e.idx       = k;
    e.data      = f % 65536;
    e.ovf       = (f > 65535) ? 1 : 0;
    e.lat       = clearPath ? (3 + k) : (2 + k - modelIdx);
    e.clrPulses = clearPath ? 1 : 0;
    e.clrStart  = clrCount;
    sbQ.push_back(e);
    modelVld = 1'b1;
    modelIdx = k;
    @(negedge clk);
    req_valid = 1'b1;
    req_idx   = IW'(k);
    check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for the response, compares it with the scoreboard head, then
  // stalls rsp_ready for 'hold' cycles before accepting it.
  task automatic checkOutput(int hold);
    exp_t e;
    int   cycles;
    logic [N-1:0] heldData;
    cycles = 1;
    while (!rsp_valid && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    if (sbQ.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sbQ.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check($sformatf("latency_k%0d", e.idx), cycles, e.lat);
    check($sformatf("rsp_data_k%0d", e.idx), rsp_data, e.data);
    check($sformatf("rsp_ovf_k%0d", e.idx), rsp_ovf, e.ovf);
    check($sformatf("gen_clr_pulses_k%0d", e.idx), clrCount - e.clrStart, e.clrPulses);
    heldData = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, heldData);
      check("hold_gen_en", gen_en, 0);
      check("hold_req_ready", req_ready, 0);
      check("hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_dropped", rsp_valid, 0);
    check("busy_after_resp", busy, 0);
  endtask

  task automatic checkResetState(string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_ovf"}, rsp_ovf, 0);
    check({tag, "_gen_clr"}, gen_clr, 0);
    check({tag, "_gen_en"}, gen_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_idx   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    applyStimulus(10);
    checkOutput(0);
    applyStimulus(12);
    checkOutput(0);
    applyStimulus(5);
    checkOutput(0);
    applyStimulus(25);
    checkOutput(0);
    applyStimulus(24);
    checkOutput(0);
    applyStimulus(24);
    checkOutput(3);
    applyStimulus(30);
    checkOutput(0);

    // Abort a long request mid-RUN; the scoreboard entry dies with it.
    applyStimulus(20);
    repeat (5) @(negedge clk);
    check("midrun_gen_en", gen_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("midrun_reset");
    sbQ.delete();
    modelVld = 1'b0;
    modelIdx = 0;

    applyStimulus(0);
    checkOutput(0);
    applyStimulus(1);
    checkOutput(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
